// File: rtl/exec_sequencer_if.sv
// rtl/exec_sequencer_if.sv - fetch, decoder, ALU, regfile and data-store signals of the sequencer
interface exec_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] inst;
    logic [7:0]  dec_opcode;
    logic [1:0]  dec_dst;
    logic        dec_src;
    logic        alu_start;
    logic        alu_done;
    logic [31:0] alu_result;
    logic        rf_we;
    logic        dmem_req;
    logic        dmem_ack;

    modport master (
        output imem_req, imem_addr, inst, alu_start, rf_we, dmem_req,
        input  imem_ack, imem_data, dec_opcode, dec_dst, dec_src,
               alu_done, alu_result, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, inst, alu_start, rf_we, dmem_req,
        output imem_ack, imem_data, dec_opcode, dec_dst, dec_src,
               alu_done, alu_result, dmem_ack
    );
endinterface

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb sequencer; SEQ_PERF_CNT_EN adds perf counters
module exec_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] PC_STEP     = 32'd4,
    parameter int          ALU_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    exec_sequencer_if.master  bus,
    output logic [31:0]       pc,
    output logic              busy,
    output logic              halted,
    output logic              fault
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       retired_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int TW = $clog2(ALU_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t        state;
    logic [TW-1:0] tcnt;
    logic [31:0]   inst_q;
    logic          imem_req_q, alu_start_q, rf_we_q, dmem_req_q;
    logic          retire;
    logic [31:0]   next_pc;
    logic          unused_dec_src;

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc;
    assign bus.inst      = inst_q;
    assign bus.alu_start = alu_start_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.dmem_req  = dmem_req_q;
    assign unused_dec_src = bus.dec_src;

    // Instruction boundary: the point where the pc advances and run is sampled.
    always_comb begin
        retire  = 1'b0;
        next_pc = pc + PC_STEP;
        case (state)
            S_EXEC: begin
                if (bus.alu_done && bus.dec_dst == 2'b10) begin
                    retire  = 1'b1;
                    next_pc = bus.alu_result;
                end else if (bus.alu_done && bus.dec_dst == 2'b00) begin
                    retire = 1'b1;
                end
            end
            S_MEM:   retire = bus.dmem_ack;
            S_WB:    retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            inst_q      <= 32'h0;
            imem_req_q  <= 1'b0;
            alu_start_q <= 1'b0;
            rf_we_q     <= 1'b0;
            dmem_req_q  <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            tcnt        <= '0;
        end else begin
            alu_start_q <= 1'b0;
            rf_we_q     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state      <= S_FETCH;
                        imem_req_q <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        inst_q     <= bus.imem_data;
                        imem_req_q <= 1'b0;
                        state      <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (bus.dec_opcode == 8'hFF) begin
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        state       <= S_EXEC;
                        alu_start_q <= 1'b1;
                        tcnt        <= '0;
                    end
                end
                S_EXEC: begin
                    if (bus.alu_done) begin
                        if (bus.dec_dst == 2'b01) begin
                            state      <= S_MEM;
                            dmem_req_q <= 1'b1;
                        end else if (bus.dec_dst == 2'b11) begin
                            state   <= S_WB;
                            rf_we_q <= 1'b1;
                        end
                    end else if (tcnt == TW'(ALU_TIMEOUT - 1)) begin
                        state  <= S_HALT;
                        fault  <= 1'b1;
                        halted <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ack) dmem_req_q <= 1'b0;
                end
                default: ;
            endcase
            // Overrides the per-state next state when an instruction completes.
            if (retire) begin
                pc <= next_pc;
                if (run) begin
                    state      <= S_FETCH;
                    imem_req_q <= 1'b1;
                end else begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            end
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic stall;
    assign stall = (state == S_FETCH && !bus.imem_ack) ||
                   (state == S_EXEC  && !bus.alu_done) ||
                   (state == S_MEM   && !bus.dmem_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= 32'h0;
            stall_cnt   <= 32'h0;
        end else begin
            if (retire) retired_cnt <= retired_cnt + 32'd1;
            if (stall)  stall_cnt   <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - directed scoreboard bench for exec_sequencer
module tb_exec_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [31:0] pc;
    logic        busy, halted, fault;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] retired_cnt, stall_cnt;
`endif

    exec_sequencer_if bus();

    exec_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .bus(bus),
        .pc(pc), .busy(busy), .halted(halted), .fault(fault)
`ifdef SEQ_PERF_CNT_EN
        , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in decoder: opcode in [7:0], destination class in [9:8], source select in [10].
    assign bus.dec_opcode = bus.inst[7:0];
    assign bus.dec_dst    = bus.inst[9:8];
    assign bus.dec_src    = bus.inst[10];

    int checks = 0;
    int errors = 0;
    int rf_we_cnt = 0, dmem_cnt = 0, imem_cnt = 0;
    int exp_stall = 0, exp_retired = 0;
    int base_rf, base_d, base_i, n;
    logic [31:0] exp_q[$];

    localparam logic [31:0] HALT_W = 32'h0000_00FF;

    always @(negedge clk) begin
        if (bus.rf_we)    rf_we_cnt++;
        if (bus.dmem_req) dmem_cnt++;
        if (bus.imem_req) imem_cnt++;
    end

    function automatic logic [31:0] mk(input logic [1:0] dst);
        return {22'h0, dst, 8'h10};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] word, input int ack_delay,
                         input bit push, input logic [31:0] next_addr);
        logic [31:0] exp_addr;
        int k = 0;
        while (bus.imem_req !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("fetch_req", {31'h0, bus.imem_req}, 32'h1);
        exp_addr = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk("fetch_addr", bus.imem_addr, exp_addr);
        if (push) exp_q.push_back(next_addr);
        repeat (ack_delay) tick();
        exp_stall += ack_delay;
        bus.imem_ack  = 1'b1;
        bus.imem_data = word;
        tick();
        bus.imem_ack = 1'b0;
        chk("inst_held", bus.inst, word);
        chk("req_drop", {31'h0, bus.imem_req}, 32'h0);
    endtask

    task automatic exec_alu(input logic [31:0] res, input int delay);
        tick();
        chk("alu_start", {31'h0, bus.alu_start}, 32'h1);
        for (int i = 0; i < delay; i++) begin
            tick();
            if (i == 0) chk("alu_start_pulse", {31'h0, bus.alu_start}, 32'h0);
        end
        exp_stall += delay;
        bus.alu_done   = 1'b1;
        bus.alu_result = res;
        tick();
        bus.alu_done = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        exp_stall = 0;
        exp_retired = 0;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_ack = 1'b0; bus.imem_data = 32'h0;
        bus.alu_done = 1'b0; bus.alu_result = 32'h0;
        bus.dmem_ack = 1'b0;
        repeat (3) tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_imem_req", {31'h0, bus.imem_req}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_inst", bus.inst, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("idle_no_req", {31'h0, bus.imem_req}, 32'h0);

        // Register-write instruction with zero-wait ALU.
        exp_q.push_back(32'h0);
        run = 1'b1;
        base_rf = rf_we_cnt;
        fetch(mk(2'b11), 1, 1'b1, 32'h4);
        exec_alu(32'h1234, 0);
        chk("wb_rf_we", {31'h0, bus.rf_we}, 32'h1);
        tick();
        exp_retired++;
        chk("wb_pc", pc, 32'h4);
        chk("wb_rf_we_cnt", rf_we_cnt - base_rf, 32'd1);
        chk("wb_busy", {31'h0, busy}, 32'h1);

        // Store with dmem_ack on the third request cycle.
        fetch(mk(2'b01), 0, 1'b1, 32'h8);
        exec_alu(32'h0, 1);
        base_d = dmem_cnt;
        tick();
        tick();
        chk("store_pc_hold", pc, 32'h4);
        bus.dmem_ack = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
        exp_stall += 2;
        exp_retired++;
        chk("store_req_cycles", dmem_cnt - base_d, 32'd3);
        chk("store_pc", pc, 32'h8);
        chk("store_req_drop", {31'h0, bus.dmem_req}, 32'h0);

        // Branch to 0x100, then a plain step, then branch back to 0x8.
        base_rf = rf_we_cnt;
        base_d  = dmem_cnt;
        fetch(mk(2'b10), 0, 1'b1, 32'h100);
        exec_alu(32'h100, 3);
        exp_retired++;
        chk("br_pc", pc, 32'h100);
        chk("br_no_rf_we", rf_we_cnt - base_rf, 32'd0);
        chk("br_no_dmem", dmem_cnt - base_d, 32'd0);
        fetch(mk(2'b00), 2, 1'b1, 32'h104);
        exec_alu(32'h0, 0);
        exp_retired++;
        chk("step_pc", pc, 32'h104);
        fetch(mk(2'b10), 0, 1'b1, 32'h8);
        exec_alu(32'h8, 0);
        exp_retired++;

        // Halt at 0x8; stray acks while halted are ignored.
        fetch(HALT_W, 0, 1'b0, 32'h0);
        tick();
        chk("halt_halted", {31'h0, halted}, 32'h1);
        chk("halt_busy", {31'h0, busy}, 32'h0);
        chk("halt_pc", pc, 32'h8);
        base_i = imem_cnt;
        bus.imem_ack  = 1'b1;
        bus.dmem_ack  = 1'b1;
        bus.imem_data = 32'hABCD_0000;
        repeat (5) tick();
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        chk("halt_no_fetch", imem_cnt - base_i, 32'd0);
        chk("halt_inst_kept", bus.inst, HALT_W);
        chk("halt_pc_kept", pc, 32'h8);
`ifdef SEQ_PERF_CNT_EN
        chk("perf_retired", retired_cnt, exp_retired);
        chk("perf_stall", stall_cnt, exp_stall);
`endif

        // ALU never completes: fault after ALU_TIMEOUT cycles.
        reset_dut();
        chk("rst_clr_halt", {31'h0, halted}, 32'h0);
        exp_q.push_back(32'h0);
        base_rf = rf_we_cnt;
        fetch(mk(2'b11), 0, 1'b0, 32'h0);
        tick();
        n = 0;
        while (fault !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("timeout_cycles", n, 32'd64);
        chk("timeout_halted", {31'h0, halted}, 32'h1);
        chk("timeout_no_rf_we", rf_we_cnt - base_rf, 32'd0);
`ifdef SEQ_PERF_CNT_EN
        chk("perf_timeout_stall", stall_cnt, 32'd64);
`endif
        reset_dut();
        chk("rst_clr_fault", {31'h0, fault}, 32'h0);

        // Reset asserted while waiting in MEM.
        exp_q.push_back(32'h0);
        fetch(mk(2'b11), 0, 1'b1, 32'h4);
        exec_alu(32'h0, 0);
        tick();
        fetch(mk(2'b01), 0, 1'b1, 32'h8);
        exec_alu(32'h0, 0);
        tick();
`ifdef SEQ_PERF_CNT_EN
        chk("perf_pre_rst_retired", retired_cnt, 32'd1);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_dmem_req", {31'h0, bus.dmem_req}, 32'h0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_imem_req", {31'h0, bus.imem_req}, 32'h0);
        chk("midrst_inst", bus.inst, 32'h0);
`ifdef SEQ_PERF_CNT_EN
        chk("midrst_retired", retired_cnt, 32'd0);
`endif
        tick();
        exp_q.delete();
        rst_n = 1'b1;
        tick();

        // Branch to the top of memory, wrap the pc, drop run mid-instruction.
        exp_q.push_back(32'h0);
        fetch(mk(2'b10), 0, 1'b1, 32'hFFFF_FFFC);
        exec_alu(32'hFFFF_FFFC, 0);
        fetch(mk(2'b00), 0, 1'b1, 32'h0);
        run = 1'b0;
        exec_alu(32'h0, 1);
        chk("wrap_pc", pc, 32'h0);
        chk("run_off_busy", {31'h0, busy}, 32'h0);
        base_i = imem_cnt;
        repeat (3) tick();
        chk("run_off_no_fetch", imem_cnt - base_i, 32'd0);
        run = 1'b1;
        fetch(mk(2'b11), 0, 1'b1, 32'h4);
        exec_alu(32'h0, 0);
        tick();
        chk("resume_pc", pc, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
